// File: rtl/fifo_pkg.sv
// Shared helpers and mode constants for the fifo_level buffer family.
package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Increment with explicit wrap at depth-1, valid for any depth.
    function automatic int wrap_inc(input int p, input int depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping 0..DEPTH-1 pointer with enable and synchronous clear.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH  = 12,
    parameter int PWIDTH = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              clr,
    input  logic              en,
    output logic [PWIDTH-1:0] ptr
);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= PWIDTH'(wrap_inc(int'(ptr), DEPTH));
        end
    end

endmodule

// File: rtl/fifo_level.sv
// Single-clock FIFO with arbitrary depth, fill level, runtime thresholds,
// sticky error flags and selectable FWFT / registered-read output.
module fifo_level
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 12,
    parameter int FWFT   = FIFO_MODE_FWFT,
    parameter int LWIDTH = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              flush,
    input  logic              shiftin,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              shiftout,
    output logic [DWIDTH-1:0] data_out,
    output logic              dout_valid,
    output logic [LWIDTH-1:0] level,
    input  logic [LWIDTH-1:0] af_thresh,
    input  logic [LWIDTH-1:0] ae_thresh,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int PWIDTH = clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PWIDTH-1:0] wr_ptr;
    logic [PWIDTH-1:0] rd_ptr;
    logic [PWIDTH-1:0] rd_ptr_nxt;
    logic [LWIDTH-1:0] level_nxt;
    logic              writing;
    logic              reading;
    logic              dout_valid_q;

    // flush blocks both sides so nothing lands in storage during a clear
    assign writing    = shiftin  && !full  && !flush;
    assign reading    = shiftout && !empty && !flush;
    assign rd_ptr_nxt = PWIDTH'(wrap_inc(int'(rd_ptr), DEPTH));
    assign level_nxt  = flush ? '0 : level + LWIDTH'(writing) - LWIDTH'(reading);
    assign dout_valid = (FWFT == FIFO_MODE_FWFT) ? !empty : dout_valid_q;

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .res (res),
        .clr (flush),
        .en  (writing),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .res (res),
        .clr (flush),
        .en  (reading),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (writing) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            level        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            level        <= level_nxt;
            full         <= (level_nxt == LWIDTH'(DEPTH));
            almost_full  <= (af_thresh != '0) && (level_nxt >= af_thresh);
            empty        <= (level_nxt == '0);
            almost_empty <= (level_nxt <= ae_thresh);
            if (flush) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (shiftin && full) begin
                    overflow <= 1'b1;
                end
                if (shiftout && empty) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            data_out     <= '0;
            dout_valid_q <= 1'b0;
        end else if (flush) begin
            dout_valid_q <= 1'b0;
        end else if (FWFT == FIFO_MODE_FWFT) begin
            dout_valid_q <= 1'b0;
            // head register tracks the oldest word; bypass when the only word leaves
            if (writing && (level == '0)) begin
                data_out <= data_in;
            end else if (reading) begin
                if (level == LWIDTH'(1)) begin
                    if (writing) begin
                        data_out <= data_in;
                    end
                end else begin
                    data_out <= mem[rd_ptr_nxt];
                end
            end
        end else begin
            dout_valid_q <= reading;
            if (reading) begin
                data_out <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_fifo_level.sv
// Directed and random checks of fifo_level in both output modes against a queue model.
module tb_fifo_level;

    localparam int DW = 16;
    localparam int DP = 12;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          res;
    logic          flush;
    logic          shiftin;
    logic          shiftout;
    logic [DW-1:0] data_in;
    logic [LW-1:0] af_thresh;
    logic [LW-1:0] ae_thresh;

    logic [DW-1:0] f_data_out, r_data_out;
    logic          f_dout_valid, r_dout_valid;
    logic [LW-1:0] f_level, r_level;
    logic          f_full, f_almost_full, f_empty, f_almost_empty, f_overflow, f_underflow;
    logic          r_full, r_almost_full, r_empty, r_almost_empty, r_overflow, r_underflow;

    fifo_level #(.DWIDTH(DW), .DEPTH(DP), .FWFT(1)) u_fwft (
        .clk(clk), .res(res), .flush(flush), .shiftin(shiftin), .data_in(data_in),
        .shiftout(shiftout), .data_out(f_data_out), .dout_valid(f_dout_valid),
        .level(f_level), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .full(f_full), .almost_full(f_almost_full), .empty(f_empty),
        .almost_empty(f_almost_empty), .overflow(f_overflow), .underflow(f_underflow)
    );

    fifo_level #(.DWIDTH(DW), .DEPTH(DP), .FWFT(0)) u_reg (
        .clk(clk), .res(res), .flush(flush), .shiftin(shiftin), .data_in(data_in),
        .shiftout(shiftout), .data_out(r_data_out), .dout_valid(r_dout_valid),
        .level(r_level), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .full(r_full), .almost_full(r_almost_full), .empty(r_empty),
        .almost_empty(r_almost_empty), .overflow(r_overflow), .underflow(r_underflow)
    );

    always #5 clk = ~clk;

    int            mq[$];
    logic          m_ov, m_un, m_af, m_ae, m_dv;
    logic [DW-1:0] m_d1, m_d0;
    int            n_err = 0;
    int            n_chk = 0;
    string         phase = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov = 1'b0; m_un = 1'b0; m_af = 1'b0; m_ae = 1'b1;
        m_dv = 1'b0; m_d1 = '0;   m_d0 = '0;
    endtask

    task automatic check_all();
        int sz;
        sz = mq.size();
        chk("f_level",   f_level,        sz);
        chk("f_full",    f_full,         sz == DP);
        chk("f_empty",   f_empty,        sz == 0);
        chk("f_afull",   f_almost_full,  m_af);
        chk("f_aempty",  f_almost_empty, m_ae);
        chk("f_ovf",     f_overflow,     m_ov);
        chk("f_unf",     f_underflow,    m_un);
        chk("f_dout",    f_data_out,     m_d1);
        chk("f_valid",   f_dout_valid,   sz != 0);
        chk("r_level",   r_level,        sz);
        chk("r_flags",   {r_full, r_almost_full, r_empty, r_almost_empty, r_overflow, r_underflow},
                         {sz == DP, m_af, sz == 0, m_ae, m_ov, m_un});
        chk("r_dout",    r_data_out,     m_d0);
        chk("r_valid",   r_dout_valid,   m_dv);
    endtask

    task automatic step(input logic si, input logic [DW-1:0] d, input logic so, input logic fl);
        bit was_full, was_empty, wr, rd;
        shiftin = si; data_in = d; shiftout = so; flush = fl;
        @(posedge clk);
        was_full  = (mq.size() == DP);
        was_empty = (mq.size() == 0);
        if (fl) begin
            mq.delete();
            m_ov = 1'b0; m_un = 1'b0; m_dv = 1'b0;
        end else begin
            wr = si && !was_full;
            rd = so && !was_empty;
            if (si && was_full)  m_ov = 1'b1;
            if (so && was_empty) m_un = 1'b1;
            m_dv = rd;
            if (rd) begin
                m_d0 = DW'(mq[0]);
                void'(mq.pop_front());
            end
            if (wr) mq.push_back(int'(d));
        end
        if (mq.size() != 0) m_d1 = DW'(mq[0]);
        m_af = (af_thresh != 0) && (mq.size() >= int'(af_thresh));
        m_ae = (mq.size() <= int'(ae_thresh));
        #1;
        check_all();
    endtask

    initial begin
        res = 1'b1; flush = 1'b0; shiftin = 1'b0; shiftout = 1'b0; data_in = '0;
        af_thresh = 4'd10; ae_thresh = 4'd2;
        #1;
        phase = "reset";
        model_reset();
        check_all();
        @(negedge clk);
        res = 1'b0;

        phase = "fill";
        for (int i = 1; i <= 12; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        phase = "overflow";
        step(1'b1, 16'h00FF, 1'b0, 1'b0);

        phase = "drain";
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0);
        phase = "underflow";
        step(1'b0, '0, 1'b1, 1'b0);

        phase = "wrap";
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
        for (int i = 5; i < 35; i++) step(1'b1, DW'(16'h0100 + i), 1'b1, 1'b0);

        phase = "bypass";
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 16'hAAAA, 1'b0, 1'b0);
        step(1'b1, 16'hBBBB, 1'b1, 1'b0);
        chk("bypass_dout", f_data_out, 16'hBBBB);

        phase = "regread";
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        step(1'b1, 16'h5678, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("reg_first", r_data_out, 16'h1234);
        step(1'b0, '0, 1'b0, 1'b0);

        phase = "flush";
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) step(1'b1, DW'(16'h0200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h7777, 1'b0, 1'b1);
        step(1'b1, 16'h0300, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        phase = "thresh";
        for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h0400 + i), 1'b0, 1'b0);
        af_thresh = 4'd4; ae_thresh = 4'd5;
        step(1'b0, '0, 1'b0, 1'b0);
        af_thresh = 4'd0; ae_thresh = 4'd0;
        step(1'b0, '0, 1'b0, 1'b0);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            if ((i % 16) == 0) begin
                af_thresh = LW'($urandom_range(0, DP));
                ae_thresh = LW'($urandom_range(0, DP));
            end
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0));
        end

        phase = "midreset";
        for (int i = 0; i < 6; i++) step(1'b1, DW'(16'h0500 + i), 1'b0, 1'b0);
        res = 1'b1;
        #2;
        model_reset();
        check_all();
        res = 1'b0;
        step(1'b1, 16'h0600, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
